// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger event front end.
package trigger_pkg;

   localparam logic [1:0] EDGE_OFF  = 2'b00;
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;
   localparam logic [1:0] EDGE_BOTH = 2'b11;

   localparam int TRIGGER_NUM_DEF = 7;

endpackage

// File: rtl/trigger_sync.sv
// Per-bit multi-flop synchroniser, vectorised; STAGES = 0 is a wire.
module trigger_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   if (STAGES == 0) begin : g_bypass
      assign q_o = d_i;
   end else begin : g_sync
      logic [W-1:0] sync_q [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
         end else begin
            sync_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
         end
      end

      assign q_o = sync_q[STAGES-1];
   end

endmodule

// File: rtl/trigger_event_ctrl.sv
// Multi-channel trigger edge detector with sticky pending flags,
// lowest-index-first event presentation and per-channel overrun.
module trigger_event_ctrl
   import trigger_pkg::*;
#(
   parameter int TRIGGER_NUM = TRIGGER_NUM_DEF,
   parameter int SYNC_STAGES = 2,
   localparam int IDX_W = (TRIGGER_NUM > 1) ? $clog2(TRIGGER_NUM) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [TRIGGER_NUM-1:0]   trigger_in,
   input  logic [2*TRIGGER_NUM-1:0] edge_mode,
   output logic [TRIGGER_NUM-1:0]   trigger_out,
   output logic [TRIGGER_NUM-1:0]   pending,
   output logic                     evt_valid,
   output logic [IDX_W-1:0]         evt_idx,
   input  logic                     evt_ready,
   output logic [TRIGGER_NUM-1:0]   overrun,
   input  logic [TRIGGER_NUM-1:0]   overrun_clr
);

   // Priming spans the sync pipeline so prev only ever holds real samples;
   // a line held high through reset then never looks like a rising edge.
   localparam int PRIME_CNT = SYNC_STAGES + 1;
   localparam int PRIME_W   = $clog2(PRIME_CNT + 1);
   localparam logic [PRIME_W-1:0] PRIME_MAX = PRIME_W'(PRIME_CNT);

   logic [TRIGGER_NUM-1:0] s;
   logic [TRIGGER_NUM-1:0] prev_q;
   logic [TRIGGER_NUM-1:0] trig_q, trig_d;
   logic [TRIGGER_NUM-1:0] pend_q, pend_d;
   logic [TRIGGER_NUM-1:0] ovr_q, ovr_d;
   logic [PRIME_W-1:0]     prime_q, prime_d;
   logic                   primed;

   logic [TRIGGER_NUM-1:0] rise, fall, det, acc_oh;
   logic [IDX_W-1:0]       idx;

   trigger_sync #(
      .W      (TRIGGER_NUM),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (trigger_in),
      .q_o   (s)
   );

   assign primed  = (prime_q == PRIME_MAX);
   assign prime_d = primed ? prime_q : prime_q + 1'b1;

   assign rise = s & ~prev_q;
   assign fall = ~s & prev_q;

   always_comb begin
      det = '0;
      for (int i = 0; i < TRIGGER_NUM; i++) begin
         case (edge_mode[2*i +: 2])
            EDGE_RISE: det[i] = rise[i];
            EDGE_FALL: det[i] = fall[i];
            EDGE_BOTH: det[i] = rise[i] | fall[i];
            default:   det[i] = 1'b0;
         endcase
      end
      if (!primed) det = '0;
   end

   always_comb begin
      idx = '0;
      for (int i = TRIGGER_NUM - 1; i >= 0; i--) begin
         if (pend_q[i]) idx = IDX_W'(i);
      end
   end

   assign evt_valid = |pend_q;
   assign evt_idx   = idx;

   always_comb begin
      acc_oh = '0;
      if (evt_valid && evt_ready) acc_oh[idx] = 1'b1;
   end

   // An edge on a channel being accepted this cycle replaces the old event.
   assign trig_d = det;
   assign pend_d = (pend_q & ~acc_oh) | det;
   assign ovr_d  = (ovr_q & ~overrun_clr) | (det & pend_q & ~acc_oh);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= '0;
         trig_q  <= '0;
         pend_q  <= '0;
         ovr_q   <= '0;
         prime_q <= '0;
      end else begin
         prev_q  <= s;
         trig_q  <= trig_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         prime_q <= prime_d;
      end
   end

   assign trigger_out = trig_q;
   assign pending     = pend_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_trigger_event_ctrl.sv
// Directed bench for trigger_event_ctrl (7 channels, 2 sync stages).
module tb_trigger_event_ctrl;

   localparam int N = 7;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] trigger_in;
   logic [13:0]  edge_mode;
   logic [N-1:0] trigger_out;
   logic [N-1:0] pending;
   logic         evt_valid;
   logic [2:0]   evt_idx;
   logic         evt_ready;
   logic [N-1:0] overrun;
   logic [N-1:0] overrun_clr;

   int checks   = 0;
   int failures = 0;
   int pulses;
   logic [1:0] m;

   trigger_event_ctrl #(
      .TRIGGER_NUM (N),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .trigger_in  (trigger_in),
      .edge_mode   (edge_mode),
      .trigger_out (trigger_out),
      .pending     (pending),
      .evt_valid   (evt_valid),
      .evt_idx     (evt_idx),
      .evt_ready   (evt_ready),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      trigger_in  = 7'h7F;
      edge_mode   = 14'h1555;
      evt_ready   = 1'b0;
      overrun_clr = '0;
      #12;
      chk("rst_trig", 32'(trigger_out), 32'h0);
      chk("rst_pend", 32'(pending), 32'h0);
      chk("rst_valid", 32'(evt_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Lines high through reset: priming must suppress the late rise
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (trigger_out != 0) pulses++;
      end
      chk("prime_pulses", 32'(pulses), 32'h0);
      chk("prime_pend", 32'(pending), 32'h0);
      chk("prime_valid", 32'(evt_valid), 32'h0);

      // Ch3 rising edge latency
      trigger_in = 7'h00;
      repeat (4) step();
      chk("fall_ignored", 32'(pending), 32'h0);
      trigger_in = 7'h08;
      step();
      step();
      chk("ch3_k1_trig", 32'(trigger_out), 32'h0);
      step();
      chk("ch3_trig", 32'(trigger_out), 32'h08);
      chk("ch3_pend", 32'(pending), 32'h08);
      chk("ch3_valid", 32'(evt_valid), 32'h1);
      chk("ch3_idx", 32'(evt_idx), 32'h3);
      step();
      chk("ch3_trig_one", 32'(trigger_out), 32'h0);
      chk("ch3_pend_hold", 32'(pending), 32'h08);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      chk("ch3_drain", 32'(pending), 32'h0);
      chk("ch3_idx0", 32'(evt_idx), 32'h0);

      // Mode sweep on ch0 with a 0->1->0 pulse
      evt_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: m = 2'b01;
            1: m = 2'b10;
            2: m = 2'b11;
            default: m = 2'b00;
         endcase
         edge_mode = {12'h555, m};
         repeat (2) step();
         pulses = 0;
         trigger_in[0] = 1'b1;
         for (int c = 0; c < 10; c++) begin
            if (c == 4) trigger_in[0] = 1'b0;
            step();
            if (trigger_out[0]) pulses++;
         end
         case (k)
            0: chk("mode01", 32'(pulses), 32'd1);
            1: chk("mode10", 32'(pulses), 32'd1);
            2: chk("mode11", 32'(pulses), 32'd2);
            default: chk("mode00", 32'(pulses), 32'd0);
         endcase
      end
      edge_mode = 14'h1555;
      step();
      evt_ready = 1'b0;
      chk("sweep_drained", 32'(pending), 32'h0);

      // Simultaneous edges on ch1, ch4, ch6 drain in index order
      evt_ready  = 1'b1;
      trigger_in = 7'h5A;
      step();
      step();
      step();
      chk("multi_pend", 32'(pending), 32'h52);
      chk("multi_idx1", 32'(evt_idx), 32'h1);
      step();
      chk("multi_idx4", 32'(evt_idx), 32'h4);
      step();
      chk("multi_idx6", 32'(evt_idx), 32'h6);
      step();
      chk("multi_empty", 32'(evt_valid), 32'h0);
      evt_ready = 1'b0;

      // Ch2 overrun, set-wins-over-clear, then plain clear
      trigger_in = 7'h5E;
      repeat (3) step();
      chk("ch2_pend", 32'(pending), 32'h04);
      trigger_in = 7'h5A;
      repeat (3) step();
      trigger_in = 7'h5E;
      repeat (3) step();
      chk("ch2_ovr", 32'(overrun), 32'h04);
      chk("ch2_pend_keep", 32'(pending), 32'h04);
      trigger_in = 7'h5A;
      repeat (3) step();
      trigger_in = 7'h5E;
      step();
      step();
      overrun_clr = 7'h04;
      step();
      overrun_clr = 7'h00;
      chk("ch2_setwins", 32'(overrun), 32'h04);
      overrun_clr = 7'h04;
      step();
      overrun_clr = 7'h00;
      chk("ch2_clr", 32'(overrun), 32'h0);
      chk("ch2_pend_after", 32'(pending), 32'h04);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      chk("ch2_drain", 32'(pending), 32'h0);

      // Ch5 accept in same cycle as new edge
      trigger_in = 7'h7E;
      repeat (3) step();
      chk("ch5_pend", 32'(pending), 32'h20);
      trigger_in = 7'h5E;
      repeat (3) step();
      trigger_in = 7'h7E;
      step();
      step();
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      chk("ch5_pend_keep", 32'(pending), 32'h20);
      chk("ch5_no_ovr", 32'(overrun), 32'h0);

      // Async reset mid-stream
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pend", 32'(pending), 32'h0);
      chk("mid_rst_valid", 32'(evt_valid), 32'h0);
      chk("mid_rst_ovr", 32'(overrun), 32'h0);
      chk("mid_rst_trig", 32'(trigger_out), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
